// File: rtl/arith_unit_scheduler_if.sv
// Bundles the two request channels and the response channel of the shared arithmetic unit.
// master = requesters/consumer side, slave = the scheduler.
interface arith_unit_scheduler_if #(
    parameter int WIDTH = 8
);
    logic               req0_valid;
    logic               req0_ready;
    logic               req0_op;
    logic [WIDTH-1:0]   req0_a;
    logic [WIDTH-1:0]   req0_b;
    logic               req1_valid;
    logic               req1_ready;
    logic               req1_op;
    logic [WIDTH-1:0]   req1_a;
    logic [WIDTH-1:0]   req1_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_id;
    logic               rsp_op;
    logic [2*WIDTH-1:0] rsp_data;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_op, rsp_data
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_op, rsp_data
    );
endinterface

// File: rtl/arith_unit_scheduler.sv
// One adder and one iterative shift-add multiplier shared by two requesters,
// round-robin arbitrated, with a single held response slot.
module arith_unit_scheduler #(
    parameter int WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_resetn,
    arith_unit_scheduler_if.slave io_bus,
    output logic                  o_busy
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_MUL, S_DONE} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_rr;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_rsp_id;
    logic                 r_rsp_op;
    logic [2*WIDTH-1:0]   r_rsp_data;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;

    logic                 w_gnt0;
    logic                 w_gnt1;
    logic                 w_ready0;
    logic                 w_ready1;
    logic                 w_accept;
    logic                 w_op;
    logic [WIDTH-1:0]     w_sel_a;
    logic [WIDTH-1:0]     w_sel_b;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_acc_nxt;
    logic                 w_rsp_hs;

    // rr pointer only matters when both requesters are valid
    assign w_gnt1    = io_bus.req1_valid && (!io_bus.req0_valid || r_rr);
    assign w_gnt0    = io_bus.req0_valid && !w_gnt1;
    assign w_op      = w_gnt1 ? io_bus.req1_op : io_bus.req0_op;
    assign w_sel_a   = w_gnt1 ? io_bus.req1_a  : io_bus.req0_a;
    assign w_sel_b   = w_gnt1 ? io_bus.req1_b  : io_bus.req0_b;
    assign w_accept  = w_ready0 || w_ready1;
    assign w_rsp_hs  = (r_state == S_DONE) && io_bus.rsp_ready;

    // the add reuses the operand registers that the multiplier loads at accept
    assign w_sum     = {1'b0, r_mcand[WIDTH-1:0]} + {1'b0, r_mplier};
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready0    = 1'b0;
        w_ready1    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_resetn) begin
                    w_ready0 = w_gnt0;
                    w_ready1 = w_gnt1;
                    if (w_gnt0 || w_gnt1) begin
                        w_state_nxt = w_op ? S_MUL : S_ADD;
                    end
                end
            end
            S_ADD:   w_state_nxt = S_DONE;
            S_MUL:   if (r_cnt == CNT_LAST) w_state_nxt = S_DONE;
            S_DONE:  if (io_bus.rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_rr       <= 1'b0;
            r_cnt      <= '0;
            r_rsp_id   <= 1'b0;
            r_rsp_op   <= 1'b0;
            r_rsp_data <= '0;
        end else begin
            if (w_accept) begin
                r_rsp_id <= w_gnt1;
                r_rsp_op <= w_op;
                r_cnt    <= '0;
            end
            if (r_state == S_MUL) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == S_ADD) begin
                r_rsp_data <= {{(WIDTH-1){1'b0}}, w_sum};
            end
            if ((r_state == S_MUL) && (r_cnt == CNT_LAST)) begin
                r_rsp_data <= w_acc_nxt;
            end
            if (w_rsp_hs) begin
                r_rr <= ~r_rsp_id;
            end
        end
    end

    // operand/accumulator registers are always loaded before use, so no reset
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_sel_a};
            r_mplier <= w_sel_b;
            r_acc    <= '0;
        end else if (r_state == S_MUL) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

    assign io_bus.req0_ready = w_ready0;
    assign io_bus.req1_ready = w_ready1;
    assign io_bus.rsp_valid  = (r_state == S_DONE);
    assign io_bus.rsp_id     = r_rsp_id;
    assign io_bus.rsp_op     = r_rsp_op;
    assign io_bus.rsp_data   = r_rsp_data;
    assign o_busy            = (r_state != S_IDLE);
endmodule

// File: tb/tb_arith_unit_scheduler.sv
// Directed bench for arith_unit_scheduler: latency, arbitration, back-pressure and reset.
module tb_arith_unit_scheduler;
    logic clk;
    logic resetn;
    logic busy;
    int   n_tests;
    int   n_fail;

    arith_unit_scheduler_if #(.WIDTH(8)) bus ();

    arith_unit_scheduler #(.WIDTH(8)) dut (
        .i_clk    (clk),
        .i_resetn (resetn),
        .io_bus   (bus),
        .o_busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rsp(input int max, inout int n);
        while (!bus.rsp_valid && n < max) begin
            tick();
            n++;
        end
    endtask

    task automatic clear_reqs();
        bus.req0_valid = 1'b0; bus.req0_op = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_op = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
    endtask

    task automatic drive(input int id, input logic op, input logic [7:0] a, input logic [7:0] b);
        if (id == 0) begin
            bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    // One lone-requester transaction: accept, latency, result, handshake.
    task automatic do_op(input string tag, input int id, input logic op,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp_data, input int exp_lat);
        int n;
        drive(id, op, a, b);
        #1;
        chk({tag, "_ready"}, (id == 0) ? bus.req0_ready : bus.req1_ready, 1);
        tick();
        clear_reqs();
        n = 1;
        wait_rsp(40, n);
        chk({tag, "_lat"},  n, exp_lat);
        chk({tag, "_data"}, bus.rsp_data, exp_data);
        chk({tag, "_id"},   bus.rsp_id, id);
        chk({tag, "_op"},   bus.rsp_op, op);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk({tag, "_vld_clr"}, bus.rsp_valid, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rdy0"}, bus.req0_ready, 0);
        chk({tag, "_rdy1"}, bus.req1_ready, 0);
        chk({tag, "_vld"},  bus.rsp_valid, 0);
        chk({tag, "_id"},   bus.rsp_id, 0);
        chk({tag, "_op"},   bus.rsp_op, 0);
        chk({tag, "_data"}, bus.rsp_data, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int n;
        int seen;
        logic exp_id;
        n_tests = 0;
        n_fail  = 0;
        resetn  = 1'b0;
        clear_reqs();
        bus.rsp_ready = 1'b0;

        // reset state, with a pending request that must not see ready
        bus.req0_valid = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        bus.req0_valid = 1'b0;
        resetn = 1'b1;
        tick();

        // basic add and multiplies, including zero and max operands
        do_op("add_30_14", 0, 1'b0, 8'h30, 8'h14, 16'h0044, 2);
        do_op("mul_fc_04", 1, 1'b1, 8'hFC, 8'h04, 16'h03F0, 9);
        do_op("mul_ff_ff", 0, 1'b1, 8'hFF, 8'hFF, 16'hFE01, 9);
        do_op("mul_00_5a", 1, 1'b1, 8'h00, 8'h5A, 16'h0000, 9);
        do_op("add_00_00", 0, 1'b0, 8'h00, 8'h00, 16'h0000, 2);

        // round-robin from reset with both requesters always valid
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        drive(0, 1'b0, 8'h01, 8'h01);
        drive(1, 1'b0, 8'h02, 8'h02);
        bus.rsp_ready = 1'b1;
        exp_id = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            wait_rsp(20, n);
            chk("rr_vld",  bus.rsp_valid, 1);
            chk("rr_id",   bus.rsp_id, exp_id);
            chk("rr_data", bus.rsp_data, exp_id ? 16'h0004 : 16'h0002);
            exp_id = ~exp_id;
            tick();
        end
        clear_reqs();
        bus.rsp_ready = 1'b0;
        tick();

        // back-pressure: response held, readies stay low, no accept on handshake
        drive(0, 1'b0, 8'hFF, 8'hFF);
        tick();
        clear_reqs();
        tick();
        drive(0, 1'b0, 8'h11, 8'h22);
        drive(1, 1'b0, 8'h33, 8'h44);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_vld",  bus.rsp_valid, 1);
            chk("bp_data", bus.rsp_data, 16'h01FE);
            chk("bp_rdy0", bus.req0_ready, 0);
            chk("bp_rdy1", bus.req1_ready, 0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_hs_vld",  bus.rsp_valid, 1);
        chk("bp_hs_data", bus.rsp_data, 16'h01FE);
        chk("bp_hs_rdy0", bus.req0_ready, 0);
        chk("bp_hs_rdy1", bus.req1_ready, 0);
        tick();
        clear_reqs();
        bus.rsp_ready = 1'b0;
        chk("bp_after_vld", bus.rsp_valid, 0);
        tick();

        // reset in the middle of a multiply
        drive(1, 1'b1, 8'h12, 8'h34);
        tick();
        clear_reqs();
        tick();
        tick();
        tick();
        resetn = 1'b0;
        #1;
        check_all_zero("midrst");
        tick();
        resetn = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.rsp_valid) seen++;
        end
        chk("midrst_no_rsp", seen, 0);
        do_op("post_rst_add", 1, 1'b0, 8'h01, 8'h01, 16'h0002, 2);

        // req0 withdraws while req1 keeps waiting
        drive(1, 1'b0, 8'h03, 8'h04);
        #1;
        chk("wd_first_rdy1", bus.req1_ready, 1);
        tick();
        drive(1, 1'b0, 8'h05, 8'h06);
        drive(0, 1'b0, 8'h09, 8'h09);
        #1;
        chk("wd_busy_rdy0", bus.req0_ready, 0);
        chk("wd_busy_rdy1", bus.req1_ready, 0);
        tick();
        chk("wd_first_data", bus.rsp_data, 16'h0007);
        chk("wd_first_id",   bus.rsp_id, 1);
        bus.rsp_ready = 1'b1;
        bus.req0_valid = 1'b0;
        tick();
        bus.rsp_ready = 1'b0;
        #1;
        chk("wd_rdy1", bus.req1_ready, 1);
        chk("wd_rdy0", bus.req0_ready, 0);
        tick();
        clear_reqs();
        n = 1;
        wait_rsp(20, n);
        chk("wd_lat",  n, 2);
        chk("wd_data", bus.rsp_data, 16'h000B);
        chk("wd_id",   bus.rsp_id, 1);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus.rsp_valid) seen++;
            tick();
        end
        chk("wd_no_stale", seen, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
